// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline package: mult/div FSM state encoding, default unit
// latencies and the counter width used by the hazard controller.
package pipeline_hazard_ctrl_pkg;

  localparam int MD_CNT_W       = 6;
  localparam int MULT_LAT_DEF   = 4;
  localparam int DIV_LAT_DEF    = 32;
  localparam int MD_LAT_MIN     = 2;
  localparam int MD_LAT_MAX     = 63;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // Counter preload for a freshly issued op. The unit is busy for exactly
  // `lat` cycles, with the last one at count zero, hence lat - 1.
  function automatic logic [MD_CNT_W-1:0] md_load_val(input logic op_div,
                                                      input int   mult_lat,
                                                      input int   div_lat);
    int lat;
    lat = op_div ? div_lat : mult_lat;
    return MD_CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_counter.sv
// md_latency_counter: 6-bit down-counter for the mult/div latency.
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset (count -> 0)
//   load_i     load load_val_i (has priority over dec_i)
//   load_val_i preload value
//   dec_i      decrement by one (held at zero, never wraps)
//   zero_o     count is zero
module md_latency_counter
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic [MD_CNT_W-1:0] load_val_i,
  input  logic                dec_i,
  output logic                zero_o
);

  logic [MD_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush generation for a 5-stage pipeline plus
// sequencing of a multi-cycle mult/div unit.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   rsD, rtD, UsesRtD     ID source registers, rt-read qualifier
//   rwE, MemtoRegE        EX destination register, EX holds a load
//   PCSrcE                taken branch/jump resolved in EX
//   MdStartD, MdOpD       ID holds mult (0) / div (1)
//   MdReadD               ID holds mfhi/mflo
//   StallF, StallD        hold PC, hold IF/ID
//   FlushD, FlushE        clear IF/ID, clear ID/EX (bubble)
//   MdIssue               start pulse to the mult/div unit
//   MdBusy, MdDone        unit busy, one-cycle completion pulse
//
// state   | meaning
// --------+---------------------------------------------------------
// MD_IDLE | unit free; a mult/div in ID may issue
// MD_BUSY | op in flight; counter runs down, MdDone at count zero
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic       UsesRtD,
  input  logic [4:0] rwE,
  input  logic       MemtoRegE,
  input  logic       PCSrcE,
  input  logic       MdStartD,
  input  logic       MdOpD,
  input  logic       MdReadD,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       FlushE,
  output logic       MdIssue,
  output logic       MdBusy,
  output logic       MdDone
);

  md_state_e           state_q, state_d;
  logic                cnt_load, cnt_dec, cnt_zero;
  logic [MD_CNT_W-1:0] cnt_load_val;

  logic load_use;
  logic md_stall;
  logic busy;

  assign busy = (state_q == MD_BUSY);

  // Register 0 is hardwired, so a load "to r0" never creates a dependency.
  assign load_use = MemtoRegE && (rwE != 5'd0) &&
                    ((rwE == rsD) || (UsesRtD && (rwE == rtD)));

  // A second mult/div or an mfhi/mflo must wait in ID until the unit has
  // gone idle; this holds through the MdDone cycle as well.
  assign md_stall = busy && (MdStartD || MdReadD);

  assign cnt_load_val = md_load_val(MdOpD, MULT_LAT, DIV_LAT);

  md_latency_counter u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    StallF   = 1'b0;
    StallD   = 1'b0;
    FlushD   = 1'b0;
    FlushE   = 1'b0;
    MdIssue  = 1'b0;
    MdBusy   = 1'b0;
    MdDone   = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    if (rst_n) begin
      // Pipeline control: branch beats load-use beats mult/div wait.
      if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (load_use || md_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end

      unique case (state_q)
        MD_IDLE: begin
          // In IDLE md_stall is zero, so StallD here can only come from a
          // load-use; gating on it keeps a held instruction from issuing twice.
          if (MdStartD && !PCSrcE && !load_use) begin
            MdIssue  = 1'b1;
            cnt_load = 1'b1;
            state_d  = MD_BUSY;
          end
        end
        MD_BUSY: begin
          MdBusy = 1'b1;
          if (cnt_zero) begin
            MdDone  = 1'b1;
            state_d = MD_IDLE;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        default: state_d = MD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] rsD, rtD, rwE;
  logic       UsesRtD, MemtoRegE, PCSrcE, MdStartD, MdOpD, MdReadD;
  logic       StallF, StallD, FlushD, FlushE, MdIssue, MdBusy, MdDone;

  int n_tests = 0;
  int n_fail  = 0;

  // Output vector order: {StallF, StallD, FlushD, FlushE, MdIssue, MdBusy, MdDone}
  localparam logic [31:0] O_NONE       = 32'b0000000;
  localparam logic [31:0] O_STALL      = 32'b1101000;
  localparam logic [31:0] O_ISSUE      = 32'b0000100;
  localparam logic [31:0] O_BUSY_STALL = 32'b1101010;
  localparam logic [31:0] O_DONE_STALL = 32'b1101011;
  localparam logic [31:0] O_FLUSH      = 32'b0011000;
  localparam logic [31:0] O_FLUSH_BUSY = 32'b0011010;
  localparam logic [31:0] O_BUSY       = 32'b0000010;
  localparam logic [31:0] O_DONE       = 32'b0000011;

  pipeline_hazard_ctrl #(
    .MULT_LAT (4),
    .DIV_LAT  (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rsD       (rsD),
    .rtD       (rtD),
    .UsesRtD   (UsesRtD),
    .rwE       (rwE),
    .MemtoRegE (MemtoRegE),
    .PCSrcE    (PCSrcE),
    .MdStartD  (MdStartD),
    .MdOpD     (MdOpD),
    .MdReadD   (MdReadD),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .FlushE    (FlushE),
    .MdIssue   (MdIssue),
    .MdBusy    (MdBusy),
    .MdDone    (MdDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] outs();
    return {25'd0, StallF, StallD, FlushD, FlushE, MdIssue, MdBusy, MdDone};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'b%0b expected 'b%0b", tag, got, exp);
    end
  endtask

  task automatic clear_in();
    rsD = 5'd0; rtD = 5'd0; rwE = 5'd0;
    UsesRtD = 1'b0; MemtoRegE = 1'b0; PCSrcE = 1'b0;
    MdStartD = 1'b0; MdOpD = 1'b0; MdReadD = 1'b0;
  endtask

  logic done_seen;

  initial begin
    clear_in();
    rst_n = 1'b0;

    // reset forces all outputs low even with hazards present
    @(negedge clk);
    MemtoRegE = 1'b1; rwE = 5'd8; rsD = 5'd8; MdStartD = 1'b1; PCSrcE = 1'b1;
    #1 check("reset_forces_zero", outs(), O_NONE);
    @(negedge clk); clear_in(); rst_n = 1'b1;
    #1 check("reset_idle", outs(), O_NONE);

    // load-use on rs, exactly one cycle
    @(negedge clk); MemtoRegE = 1'b1; rwE = 5'd8; rsD = 5'd8;
    #1 check("load_use_rs", outs(), O_STALL);
    @(negedge clk); clear_in();
    #1 check("load_use_released", outs(), O_NONE);

    // r0 destination never stalls
    @(negedge clk); MemtoRegE = 1'b1; rwE = 5'd0; rsD = 5'd0; rtD = 5'd0; UsesRtD = 1'b1;
    #1 check("load_r0_no_stall", outs(), O_NONE);

    // rt gating
    @(negedge clk); clear_in(); MemtoRegE = 1'b1; rwE = 5'd9; rtD = 5'd9; rsD = 5'd3;
    #1 check("rt_unused_no_stall", outs(), O_NONE);
    UsesRtD = 1'b1;
    #1 check("rt_used_stall", outs(), O_STALL);

    // same register but not a load
    @(negedge clk); clear_in(); rwE = 5'd8; rsD = 5'd8;
    #1 check("non_load_no_stall", outs(), O_NONE);

    // mult held back by a load-use stall, then no FSM change
    @(negedge clk); MemtoRegE = 1'b1; MdStartD = 1'b1;
    #1 check("mult_blocked_by_load_use", outs(), O_STALL);
    @(negedge clk); clear_in();
    #1 check("mult_blocked_stays_idle", outs(), O_NONE);

    // mult followed by mfhi
    @(negedge clk); MdStartD = 1'b1; MdOpD = 1'b0;
    #1 check("mult_issue", outs(), O_ISSUE);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); clear_in(); MdReadD = 1'b1;
      #1 check($sformatf("mfhi_wait_%0d", i), outs(), (i == 4) ? O_DONE_STALL : O_BUSY_STALL);
    end
    @(negedge clk);
    #1 check("mfhi_released", outs(), O_NONE);

    // branch overrides load-use
    @(negedge clk); clear_in(); MemtoRegE = 1'b1; rwE = 5'd8; rsD = 5'd8; PCSrcE = 1'b1;
    #1 check("branch_over_load_use", outs(), O_FLUSH);

    // squashed mult
    @(negedge clk); clear_in(); PCSrcE = 1'b1; MdStartD = 1'b1;
    #1 check("mult_squashed", outs(), O_FLUSH);
    @(negedge clk); clear_in();
    #1 check("squash_stays_idle", outs(), O_NONE);

    // in-flight mult survives a branch
    @(negedge clk); MdStartD = 1'b1;
    #1 check("mult2_issue", outs(), O_ISSUE);
    @(negedge clk); clear_in(); PCSrcE = 1'b1; MdReadD = 1'b1;
    #1 check("busy_branch_flush", outs(), O_FLUSH_BUSY);
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk); clear_in();
      #1 check($sformatf("mult2_busy_%0d", i), outs(), (i == 4) ? O_DONE : O_BUSY);
    end
    @(negedge clk);
    #1 check("mult2_idle", outs(), O_NONE);

    // reset in the 10th busy cycle of a divide
    @(negedge clk); MdStartD = 1'b1; MdOpD = 1'b1;
    #1 check("div_issue", outs(), O_ISSUE);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk); clear_in();
      #1 check($sformatf("div_busy_%0d", i), outs(), O_BUSY);
    end
    @(negedge clk); rst_n = 1'b0;
    #1 check("div_reset_forced", outs(), O_NONE);
    @(negedge clk); rst_n = 1'b1;
    #1 check("div_abort_idle", outs(), O_NONE);
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1 done_seen = done_seen | MdDone | MdBusy;
    end
    check("div_abort_no_done", {31'd0, done_seen}, 32'd0);

    // full divide with a mult waiting in ID, then back-to-back issue
    @(negedge clk); MdStartD = 1'b1; MdOpD = 1'b1;
    #1 check("div_full_issue", outs(), O_ISSUE);
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk); MdStartD = 1'b1; MdOpD = 1'b0;
      #1 check($sformatf("div_wait_%0d", i), outs(), (i == 32) ? O_DONE_STALL : O_BUSY_STALL);
    end
    @(negedge clk);
    #1 check("queued_mult_issue", outs(), O_ISSUE);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); clear_in();
      #1 check($sformatf("queued_mult_busy_%0d", i), outs(), (i == 4) ? O_DONE : O_BUSY);
    end
    @(negedge clk);
    #1 check("final_idle", outs(), O_NONE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL use one clock and one reset: the clock is clk; the reset is rst_n, synchronous and active-low.
REQ-002 SHALL have parameters: MULT_LAT, default 4, multiply cycles; DIV_LAT, default 32, divide cycles (both in the range 2..63).
REQ-003 SHALL have ports (name, direction, width, meaning):
- clk  in  1  clock
- rst_n  in  1  sync active-low reset
- rsD  in  5  ID source register 1
- rtD  in  5  ID source register 2
- UsesRtD  in  1  ID instruction reads rt
- rwE  in  5  EX destination register
- MemtoRegE  in  1  EX instruction is a load
- PCSrcE  in  1  branch/jump taken, resolved in EX
- MdStartD  in  1  ID holds mult/div
- MdOpD  in  1  0 = mult, 1 = div
- MdReadD  in  1  ID holds mfhi/mflo
- StallF  out  1  hold PC
- StallD  out  1  hold IF/ID
- FlushD  out  1  clear IF/ID
- FlushE  out  1  clear ID/EX (bubble)
- MdIssue  out  1  start pulse to the mult/div unit
- MdBusy  out  1  mult/div in progress
- MdDone  out  1  one-cycle completion pulse

Function
REQ-004 SHALL detect a load-use hazard when MemtoRegE=1, rwE!=0, and either rwE==rsD, or UsesRtD=1 and rwE==rtD.
REQ-005 SHALL, on a load-use hazard, assert StallF=StallD=FlushE=1 combinationally for exactly one cycle; the load then reaches MEM and forwarding resolves the dependency.
REQ-006 SHALL, when PCSrcE=1, assert FlushD=FlushE=1 and force StallF=StallD=0 in that cycle; a taken branch overrides every stall.
REQ-007 SHALL implement a two-state FSM, IDLE and BUSY, with a 6-bit down-counter.
REQ-008 SHALL accept a mult/div in IDLE when MdStartD=1, PCSrcE=0 and there is no load-use stall:
- MdIssue=1 in that cycle
- next state BUSY; counter loaded with (MdOpD ? DIV_LAT : MULT_LAT) - 1
REQ-009 SHALL, in BUSY, decrement the counter each cycle; at counter==0, assert MdDone for that cycle and move to IDLE on the next edge.
REQ-010 SHALL assert MdBusy=1 exactly while in BUSY.
REQ-011 SHALL, in BUSY, stall (StallF=StallD=FlushE=1) while the ID instruction has MdStartD=1 or MdReadD=1, including the MdDone cycle; the instruction is released in the first IDLE cycle.
REQ-012 SHALL let a mult/div already in BUSY run to completion when PCSrcE=1; a mult/div sitting in ID when PCSrcE=1 is squashed (MdIssue=0, FSM unchanged).
REQ-013 SHALL apply priority PCSrcE > load-use > mult/div stall; all outputs are combinational from state and inputs except the FSM and counter.
REQ-014 SHALL keep MdIssue=0 whenever StallD=1, so no double issue occurs.

Reset
REQ-015 SHALL, when rst_n=0 at a clk edge, set state IDLE and counter 0.
REQ-016 SHALL force StallF, StallD, FlushD, FlushE, MdIssue, MdBusy and MdDone to 0 while rst_n=0.
REQ-017 SHALL treat reset during BUSY as an abort: return to IDLE with no MdDone.

Structure
REQ-018 SHALL take the state encoding and the default MULT_LAT/DIV_LAT constants from the shared pipeline package.
REQ-019 SHALL place the latency counter in one sub-module, md_latency_counter (load, decrement, zero flag).

Verification
REQ-020 SHALL cover load-use: MemtoRegE=1, rwE=8, rsD=8 -> StallF=StallD=FlushE=1 for one cycle; with rwE=0 -> no stall.
REQ-021 SHALL cover rt gating: rwE=9, rtD=9, UsesRtD=0 -> no stall; UsesRtD=1 -> stall.
REQ-022 SHALL cover multiply then mfhi: mult issued, then mfhi in ID -> MdBusy for 4 cycles, MdDone in the 4th, stall released the next cycle.
REQ-023 SHALL cover branch priority: PCSrcE=1 while a load-use hazard is present -> FlushD=FlushE=1, StallF=StallD=0.
REQ-024 SHALL cover a squashed mult: PCSrcE=1 with MdStartD=1 in IDLE -> MdIssue=0, state stays IDLE.
REQ-025 SHALL cover reset mid-divide: rst_n=0 at cycle 10 of a div -> IDLE next cycle, MdDone never pulses.
